// File: rtl/alu_div_seq.sv
// ---------------------------------------------------------------------------
// alu_div_seq
//
// Multi-cycle radix-2 restoring divider for the execute stage. It handles
// signed and unsigned divide/remainder, the RISC-V divide-by-zero and signed
// overflow results, and a half-width word mode whose results are sign-extended
// from bit WIDTH/2-1.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   flush       synchronous abort of any in-flight operation
//   in_valid    request valid
//   in_ready    unit can accept a request (IDLE only)
//   in_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_word     1 = operate on the low WIDTH/2 bits of the operands
//   in_a        dividend
//   in_b        divisor
//   out_valid   result valid, held until accepted
//   out_ready   consumer accepts the result
//   out_result  quotient or remainder
//   busy        unit is not in IDLE
// ---------------------------------------------------------------------------
module alu_div_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_word,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] HALF_MASK = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [WIDTH-1:0] MIN_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_HALF  = {{(HALF+1){1'b0}}, {(HALF-1){1'b0}}} | (WIDTH'(1) << (HALF - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       op_reg;
    logic             word_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] bmag_reg;
    logic [CW-1:0]    cnt_reg;
    logic             qneg_reg;
    logic             rneg_reg;
    logic [WIDTH-1:0] result_reg;

    // ------------------------------------------------------------------
    // Operand preparation (evaluated while in PREP from captured operands)
    // ------------------------------------------------------------------
    logic             prep_signed;
    logic [WIDTH-1:0] a_slice, b_slice;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero, a_is_min, b_is_m1, overflow, special;
    logic [CW-1:0]    k_val;

    always_comb begin
        prep_signed = ~op_reg[0];
        a_slice     = word_reg ? (a_reg & HALF_MASK) : a_reg;
        b_slice     = word_reg ? (b_reg & HALF_MASK) : b_reg;
        sign_a      = prep_signed & (word_reg ? a_reg[HALF-1] : a_reg[WIDTH-1]);
        sign_b      = prep_signed & (word_reg ? b_reg[HALF-1] : b_reg[WIDTH-1]);
        // Negation of a half-width slice must stay inside the half-width field.
        a_mag       = sign_a ? ((-a_slice) & (word_reg ? HALF_MASK : '1)) : a_slice;
        b_mag       = sign_b ? ((-b_slice) & (word_reg ? HALF_MASK : '1)) : b_slice;
        b_zero      = (b_slice == '0);
        a_is_min    = (a_slice == (word_reg ? MIN_HALF : MIN_FULL));
        b_is_m1     = (b_slice == (word_reg ? HALF_MASK : '1));
        overflow    = prep_signed & a_is_min & b_is_m1;
        special     = b_zero | overflow;
        k_val       = word_reg ? CW'(HALF) : CW'(WIDTH);
    end

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic             shift_in;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    always_comb begin
        // In word mode the dividend lives in the low half, so the bit that
        // moves into the remainder is the top of that half.
        shift_in  = word_reg ? quo_reg[HALF-1] : quo_reg[WIDTH-1];
        rem_shift = {rem_reg, shift_in};
        trial     = rem_shift - {1'b0, bmag_reg};
        quo_step  = {quo_reg[WIDTH-2:0], 1'b0};
        rem_step  = rem_shift[WIDTH-1:0];
        // rem < |b| keeps a non-negative difference below 2^WIDTH, so the
        // top bit of the trial is a clean borrow flag.
        if (!trial[WIDTH]) begin
            rem_step    = trial[WIDTH-1:0];
            quo_step[0] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_fix, r_fix, sel_fix, res_fix;

    always_comb begin
        q_fix   = qneg_reg ? -quo_reg : quo_reg;
        r_fix   = rneg_reg ? -rem_reg : rem_reg;
        sel_fix = op_reg[1] ? r_fix : q_fix;
        res_fix = word_reg ? {{HALF{sel_fix[HALF-1]}}, sel_fix[HALF-1:0]} : sel_fix;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_PREP;
            S_PREP:  state_next = special ? S_FIX : S_ITER;
            S_ITER:  if (cnt_reg == CW'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg     <= '0;
            word_reg   <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            bmag_reg   <= '0;
            cnt_reg    <= '0;
            qneg_reg   <= 1'b0;
            rneg_reg   <= 1'b0;
            result_reg <= '0;
        end else if (!flush) begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        op_reg   <= in_op;
                        word_reg <= in_word;
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                    end
                end
                S_PREP: begin
                    bmag_reg <= b_mag;
                    cnt_reg  <= k_val;
                    if (b_zero) begin
                        quo_reg  <= word_reg ? HALF_MASK : '1;
                        rem_reg  <= a_slice;
                        qneg_reg <= 1'b0;
                        rneg_reg <= 1'b0;
                    end else if (overflow) begin
                        quo_reg  <= a_slice;
                        rem_reg  <= '0;
                        qneg_reg <= 1'b0;
                        rneg_reg <= 1'b0;
                    end else begin
                        quo_reg  <= a_mag;
                        rem_reg  <= '0;
                        qneg_reg <= sign_a ^ sign_b;
                        rneg_reg <= sign_a;
                    end
                end
                S_ITER: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg - CW'(1);
                end
                S_FIX: begin
                    result_reg <= res_fix;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign out_result = result_reg;

endmodule
